// File: rtl/ppu_reg_port.sv
// ppu_reg_port -- CPU-facing register port of a PPU.
//
// Decodes the eight CPU registers (control, mask, status, OAM pointer/data,
// scroll, address, data) and runs the VRAM access sequencer for register 7.
// The palette RAM is held locally so that palette accesses complete without
// a VRAM cycle.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cpu_cs/rw/sel/wdata          one-cycle CPU access strobe and payload
//   cpu_rdata, cpu_rvalid        registered read data and its one-cycle valid
//   cpu_ready                    low while a VRAM request is outstanding
//   vram_req/we/addr/wdata       VRAM request, held stable until vram_ack
//   vram_rdata, vram_ack         VRAM read data and completion
//   oam_addr/wdata/we            OAM pointer, data and write pulse
//   set_vblank, clr_vblank,
//   set_sprite0, set_overflow    status events from the renderer
//   pal_idx, pal_color           renderer palette lookup (one-cycle latency)
//   ctrl, mask                   control and mask registers
//   v_addr, t_addr, fine_x       scroll/address state
//   nmi_n                        active-low NMI
//   access_err                   sticky flag: a register-7 access was dropped
module ppu_reg_port #(
   parameter int ADDR_W     = 14,
   parameter int PAL_W      = 6,
   parameter int INC_COARSE = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_cs,
   input  logic              cpu_rw,
   input  logic [2:0]        cpu_sel,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_ready,
   output logic              vram_req,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   input  logic [7:0]        vram_rdata,
   input  logic              vram_ack,
   output logic [7:0]        oam_addr,
   output logic [7:0]        oam_wdata,
   output logic              oam_we,
   input  logic              set_vblank,
   input  logic              clr_vblank,
   input  logic              set_sprite0,
   input  logic              set_overflow,
   input  logic [4:0]        pal_idx,
   output logic [PAL_W-1:0]  pal_color,
   output logic [7:0]        ctrl,
   output logic [7:0]        mask,
   output logic [14:0]       v_addr,
   output logic [14:0]       t_addr,
   output logic [2:0]        fine_x,
   output logic              nmi_n,
   output logic              access_err
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   localparam logic [PAL_W-1:0] GREY_MASK = PAL_W'(8'h30);

   state_t              state, stateNext;
   logic [14:0]         v, t;
   logic                w;
   logic [7:0]          latch;
   logic [7:0]          rbuf;
   logic                vblank, sprite0, overflow;
   logic [ADDR_W-1:0]   reqAddr;
   logic [7:0]          reqWdata;
   logic [PAL_W-1:0]    palette [32];

   // Access decode
   logic        isWrite, isRead, statusRead;
   logic        sel7Hit, sel7Go, sel7Drop;
   logic        inPal, startRd, startWr, palWe;
   logic [4:0]  vPalIdx, rendIdx;
   logic [14:0] vInc, reqSrc;

   assign isWrite    = cpu_cs & ~cpu_rw;
   assign isRead     = cpu_cs & cpu_rw;
   assign statusRead = isRead && (cpu_sel == 3'd2);
   assign sel7Hit    = cpu_cs && (cpu_sel == 3'd7);
   assign sel7Go     = sel7Hit && (state == IDLE);
   assign sel7Drop   = sel7Hit && (state != IDLE);

   assign inPal   = (v[13:8] == 6'h3F);
   // 0x10/0x14/0x18/0x1C alias the backdrop entries 0x00/0x04/0x08/0x0C
   assign vPalIdx = {v[4] & (v[1:0] != 2'b00), v[3:0]};
   assign rendIdx = (pal_idx[1:0] == 2'b00) ? 5'd0 : pal_idx;

   assign startRd = sel7Go && cpu_rw;
   assign startWr = sel7Go && !cpu_rw && !inPal;
   assign palWe   = sel7Go && !cpu_rw && inPal;
   assign vInc    = ctrl[2] ? 15'(INC_COARSE) : 15'd1;
   // A palette read still refills rbuf, from the nametable underneath it
   assign reqSrc  = (cpu_rw && inPal) ? {v[14:13], 1'b0, v[11:0]} : v;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // FSM: next state and request outputs
   always_comb begin
      stateNext = state;
      vram_req  = 1'b0;
      vram_we   = 1'b0;
      cpu_ready = 1'b0;
      case (state)
         IDLE: begin
            cpu_ready = 1'b1;
            if (startRd)      stateNext = RD_WAIT;
            else if (startWr) stateNext = WR_WAIT;
         end
         RD_WAIT: begin
            vram_req = 1'b1;
            if (vram_ack) stateNext = IDLE;
         end
         WR_WAIT: begin
            vram_req = 1'b1;
            vram_we  = 1'b1;
            if (vram_ack) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign vram_addr  = reqAddr;
   assign vram_wdata = reqWdata;

   // Register file, scroll state, status and read path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl       <= '0;
         mask       <= '0;
         v          <= '0;
         t          <= '0;
         fine_x     <= '0;
         w          <= 1'b0;
         latch      <= '0;
         rbuf       <= '0;
         vblank     <= 1'b0;
         sprite0    <= 1'b0;
         overflow   <= 1'b0;
         oam_addr   <= '0;
         oam_wdata  <= '0;
         oam_we     <= 1'b0;
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         access_err <= 1'b0;
         reqAddr    <= '0;
         reqWdata   <= '0;
      end else begin
         cpu_rvalid <= 1'b0;
         oam_we     <= 1'b0;

         if (isWrite) begin
            latch <= cpu_wdata;
            case (cpu_sel)
               3'd0: begin
                  ctrl      <= cpu_wdata;
                  t[11:10]  <= cpu_wdata[1:0];
               end
               3'd1: mask     <= cpu_wdata;
               3'd3: oam_addr <= cpu_wdata;
               3'd4: begin
                  oam_wdata <= cpu_wdata;
                  oam_we    <= 1'b1;
                  oam_addr  <= oam_addr + 8'd1;
               end
               3'd5: begin
                  if (!w) begin
                     t[4:0] <= cpu_wdata[7:3];
                     fine_x <= cpu_wdata[2:0];
                  end else begin
                     t[14:12] <= cpu_wdata[2:0];
                     t[9:5]   <= cpu_wdata[7:3];
                  end
                  w <= ~w;
               end
               3'd6: begin
                  if (!w) begin
                     t[14:8] <= {1'b0, cpu_wdata[5:0]};
                  end else begin
                     t[7:0] <= cpu_wdata;
                     v      <= {t[14:8], cpu_wdata};
                  end
                  w <= ~w;
               end
               default: ;
            endcase
         end

         if (isRead && !sel7Drop) begin
            cpu_rvalid <= 1'b1;
            case (cpu_sel)
               // A vblank set landing on the read is hidden and then lost
               3'd2:    cpu_rdata <= {vblank & ~set_vblank, sprite0, overflow, latch[4:0]};
               3'd7:    cpu_rdata <= inPal ? 8'(palette[vPalIdx]) : rbuf;
               default: cpu_rdata <= latch;
            endcase
         end

         if (statusRead) w <= 1'b0;

         if (sel7Go) v <= v + vInc;
         if (startRd || startWr) begin
            reqAddr  <= ADDR_W'(reqSrc);
            reqWdata <= cpu_wdata;
         end
         if (sel7Drop) access_err <= 1'b1;

         if (state == RD_WAIT && vram_ack) rbuf <= vram_rdata;

         // Clears take priority over the renderer's set events
         if (clr_vblank || statusRead) vblank <= 1'b0;
         else if (set_vblank)          vblank <= 1'b1;
         if (clr_vblank)        sprite0 <= 1'b0;
         else if (set_sprite0)  sprite0 <= 1'b1;
         if (clr_vblank)        overflow <= 1'b0;
         else if (set_overflow) overflow <= 1'b1;
      end
   end

   // Palette storage and renderer lookup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) palette[i] <= '0;
         pal_color <= '0;
      end else begin
         if (palWe) palette[vPalIdx] <= cpu_wdata[PAL_W-1:0];
         pal_color <= palette[rendIdx] & (mask[0] ? GREY_MASK : {PAL_W{1'b1}});
      end
   end

   assign v_addr = v;
   assign t_addr = t;
   assign nmi_n  = ~(vblank & ctrl[7]);

endmodule

// File: tb/tb_ppu_reg_port.sv
// tb_ppu_reg_port -- directed self-checking bench for ppu_reg_port.
// Each task covers one feature and checks its own expected values inline.
module tb_ppu_reg_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_cs, cpu_rw;
   logic [2:0]  cpu_sel;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_rvalid, cpu_ready;
   logic        vram_req, vram_we;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata, vram_rdata;
   logic        vram_ack;
   logic [7:0]  oam_addr, oam_wdata;
   logic        oam_we;
   logic        set_vblank, clr_vblank, set_sprite0, set_overflow;
   logic [4:0]  pal_idx;
   logic [5:0]  pal_color;
   logic [7:0]  ctrl, mask;
   logic [14:0] v_addr, t_addr;
   logic [2:0]  fine_x;
   logic        nmi_n, access_err;

   int checks   = 0;
   int failures = 0;

   ppu_reg_port #(.ADDR_W(14), .PAL_W(6), .INC_COARSE(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_ready(cpu_ready),
      .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
      .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
      .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
      .set_vblank(set_vblank), .clr_vblank(clr_vblank),
      .set_sprite0(set_sprite0), .set_overflow(set_overflow),
      .pal_idx(pal_idx), .pal_color(pal_color),
      .ctrl(ctrl), .mask(mask), .v_addr(v_addr), .t_addr(t_addr),
      .fine_x(fine_x), .nmi_n(nmi_n), .access_err(access_err)
   );

   always #5 clk = ~clk;

   // Stimulus helpers: called at a negedge, return at the next negedge
   task automatic cpu_wr(input logic [2:0] sel, input logic [7:0] d);
      cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_sel = sel; cpu_wdata = d;
      @(negedge clk);
      cpu_cs = 1'b0;
      $display("txn wr sel=%0d data=%h", sel, d);
   endtask

   task automatic cpu_rd(input logic [2:0] sel);
      cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_sel = sel; cpu_wdata = 8'h00;
      @(negedge clk);
      cpu_cs = 1'b0;
      $display("txn rd sel=%0d rvalid=%0b rdata=%h", sel, cpu_rvalid, cpu_rdata);
   endtask

   task automatic wait_req(output logic ok);
      for (int i = 0; i < 20 && !vram_req; i++) @(negedge clk);
      ok = vram_req;
   endtask

   task automatic vram_ack_cycle(input logic [7:0] d);
      vram_ack = 1'b1; vram_rdata = d;
      @(negedge clk);
      vram_ack = 1'b0; vram_rdata = 8'h00;
      $display("txn vram ack data=%h", d);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (vram_req !== 1'b0) begin failures++; $display("FAIL reset_vram_req: got %b want 0", vram_req); end
      checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b want 0", cpu_rvalid); end
      checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL reset_nmi_n: got %b want 1", nmi_n); end
      checks++; if (v_addr !== 15'h0 || t_addr !== 15'h0) begin failures++; $display("FAIL reset_vt: got v=%h t=%h want 0", v_addr, t_addr); end
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", cpu_ready); end
      checks++; if (ctrl !== 8'h0 || mask !== 8'h0 || oam_addr !== 8'h0 || oam_we !== 1'b0 || access_err !== 1'b0 || pal_color !== 6'h0)
         begin failures++; $display("FAIL reset_regs: got ctrl=%h mask=%h oam=%h we=%b err=%b pal=%h want 0", ctrl, mask, oam_addr, oam_we, access_err, pal_color); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_scroll;
      cpu_wr(3'd5, 8'hFD);
      checks++; if (fine_x !== 3'd5) begin failures++; $display("FAIL scroll_fine_x: got %0d want 5", fine_x); end
      cpu_wr(3'd5, 8'h5E);
      cpu_wr(3'd0, 8'h03);
      checks++; if (t_addr !== 15'h6D7F) begin failures++; $display("FAIL scroll_t: got %h want 6d7f", t_addr); end
      checks++; if (ctrl !== 8'h03) begin failures++; $display("FAIL scroll_ctrl: got %h want 03", ctrl); end
      cpu_wr(3'd0, 8'h00);
      checks++; if (t_addr !== 15'h617F) begin failures++; $display("FAIL scroll_t_nt: got %h want 617f", t_addr); end
   endtask

   task automatic test_addr_write;
      cpu_wr(3'd6, 8'h21);
      checks++; if (t_addr !== 15'h217F) begin failures++; $display("FAIL addr_hi: got t=%h want 217f", t_addr); end
      cpu_wr(3'd6, 8'h08);
      checks++; if (v_addr !== 15'h2108 || t_addr !== 15'h2108) begin failures++; $display("FAIL addr_lo: got v=%h t=%h want 2108", v_addr, t_addr); end
      cpu_wr(3'd7, 8'h55);
      checks++; if (vram_req !== 1'b1 || vram_we !== 1'b1 || vram_addr !== 14'h2108 || vram_wdata !== 8'h55)
         begin failures++; $display("FAIL data_wr_req: got req=%b we=%b addr=%h data=%h want 1 1 2108 55", vram_req, vram_we, vram_addr, vram_wdata); end
      checks++; if (v_addr !== 15'h2109 || cpu_ready !== 1'b0) begin failures++; $display("FAIL data_wr_v: got v=%h ready=%b want 2109 0", v_addr, cpu_ready); end
      @(negedge clk);
      checks++; if (vram_req !== 1'b1 || vram_we !== 1'b1 || vram_addr !== 14'h2108 || vram_wdata !== 8'h55)
         begin failures++; $display("FAIL data_wr_hold: got req=%b we=%b addr=%h data=%h want 1 1 2108 55", vram_req, vram_we, vram_addr, vram_wdata); end
      vram_ack_cycle(8'h00);
      checks++; if (vram_req !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("FAIL data_wr_done: got req=%b ready=%b want 0 1", vram_req, cpu_ready); end
   endtask

   task automatic test_read_buffer;
      logic ok;
      cpu_wr(3'd0, 8'h04);
      cpu_wr(3'd6, 8'h20);
      cpu_wr(3'd6, 8'h00);
      cpu_rd(3'd7);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h00) begin failures++; $display("FAIL rd1_data: got valid=%b data=%h want 1 00", cpu_rvalid, cpu_rdata); end
      wait_req(ok);
      checks++; if (!ok || vram_we !== 1'b0 || vram_addr !== 14'h2000) begin failures++; $display("FAIL rd1_req: got req=%b we=%b addr=%h want 1 0 2000", vram_req, vram_we, vram_addr); end
      vram_ack_cycle(8'hAB);
      cpu_rd(3'd7);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hAB) begin failures++; $display("FAIL rd2_data: got valid=%b data=%h want 1 ab", cpu_rvalid, cpu_rdata); end
      checks++; if (v_addr !== 15'h2040) begin failures++; $display("FAIL rd2_v: got %h want 2040", v_addr); end
      @(negedge clk);
      checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rd2_pulse: got rvalid=%b want 0", cpu_rvalid); end
      wait_req(ok);
      checks++; if (!ok || vram_addr !== 14'h2020) begin failures++; $display("FAIL rd2_req: got req=%b addr=%h want 1 2020", vram_req, vram_addr); end
      vram_ack_cycle(8'hCD);
   endtask

   task automatic test_palette;
      logic ok;
      cpu_wr(3'd0, 8'h00);
      cpu_wr(3'd6, 8'h3F);
      cpu_wr(3'd6, 8'h10);
      cpu_wr(3'd7, 8'h2A);
      checks++; if (vram_req !== 1'b0 || cpu_ready !== 1'b1 || v_addr !== 15'h3F11)
         begin failures++; $display("FAIL pal_wr: got req=%b ready=%b v=%h want 0 1 3f11", vram_req, cpu_ready, v_addr); end
      pal_idx = 5'h14;
      @(negedge clk);
      checks++; if (pal_color !== 6'h2A) begin failures++; $display("FAIL pal_color: got %h want 2a", pal_color); end
      checks++; if (vram_req !== 1'b0) begin failures++; $display("FAIL pal_no_req: got %b want 0", vram_req); end
      cpu_wr(3'd6, 8'h3F);
      cpu_wr(3'd6, 8'h00);
      cpu_rd(3'd7);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h2A) begin failures++; $display("FAIL pal_rd: got valid=%b data=%h want 1 2a", cpu_rvalid, cpu_rdata); end
      wait_req(ok);
      checks++; if (!ok || vram_we !== 1'b0 || vram_addr !== 14'h2F00) begin failures++; $display("FAIL pal_refill: got req=%b we=%b addr=%h want 1 0 2f00", vram_req, vram_we, vram_addr); end
      vram_ack_cycle(8'h77);
      cpu_wr(3'd1, 8'h01);
      @(negedge clk);
      checks++; if (pal_color !== 6'h20) begin failures++; $display("FAIL pal_grey: got %h want 20", pal_color); end
      cpu_wr(3'd1, 8'h00);
   endtask

   task automatic test_vblank;
      set_vblank = 1'b1; @(negedge clk); set_vblank = 1'b0;
      checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL nmi_disabled: got %b want 1", nmi_n); end
      cpu_wr(3'd0, 8'h80);
      checks++; if (nmi_n !== 1'b0) begin failures++; $display("FAIL nmi_enable: got %b want 0", nmi_n); end
      cpu_wr(3'd5, 8'h1F);
      cpu_rd(3'd2);
      checks++; if (cpu_rdata !== 8'h9F) begin failures++; $display("FAIL status_rd: got %h want 9f", cpu_rdata); end
      checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL status_clr_nmi: got %b want 1", nmi_n); end
      cpu_wr(3'd6, 8'h12);
      checks++; if (t_addr[14:8] !== 7'h12) begin failures++; $display("FAIL status_clr_w: got t=%h want 12xx", t_addr); end
      cpu_wr(3'd6, 8'h34);
      checks++; if (v_addr !== 15'h1234) begin failures++; $display("FAIL status_v: got %h want 1234", v_addr); end
      set_vblank = 1'b1; cpu_rd(3'd2); set_vblank = 1'b0;
      checks++; if (cpu_rdata !== 8'h14) begin failures++; $display("FAIL race_rd: got %h want 14", cpu_rdata); end
      @(negedge clk);
      checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL race_vblank: got nmi_n=%b want 1", nmi_n); end
      set_vblank = 1'b1; clr_vblank = 1'b1; @(negedge clk); set_vblank = 1'b0; clr_vblank = 1'b0;
      checks++; if (nmi_n !== 1'b1) begin failures++; $display("FAIL clr_wins: got nmi_n=%b want 1", nmi_n); end
      set_sprite0 = 1'b1; set_overflow = 1'b1; @(negedge clk); set_sprite0 = 1'b0; set_overflow = 1'b0;
      cpu_rd(3'd2);
      checks++; if (cpu_rdata !== 8'h74) begin failures++; $display("FAIL sprite_bits: got %h want 74", cpu_rdata); end
      clr_vblank = 1'b1; @(negedge clk); clr_vblank = 1'b0;
      cpu_rd(3'd2);
      checks++; if (cpu_rdata !== 8'h14) begin failures++; $display("FAIL sprite_clr: got %h want 14", cpu_rdata); end
   endtask

   task automatic test_back_to_back;
      cpu_wr(3'd3, 8'hFE);
      cpu_wr(3'd4, 8'h11);
      checks++; if (oam_we !== 1'b1 || oam_addr !== 8'hFF || oam_wdata !== 8'h11)
         begin failures++; $display("FAIL oam_first: got we=%b addr=%h data=%h want 1 ff 11", oam_we, oam_addr, oam_wdata); end
      cpu_wr(3'd4, 8'h22);
      checks++; if (oam_we !== 1'b1 || oam_addr !== 8'h00 || oam_wdata !== 8'h22)
         begin failures++; $display("FAIL oam_wrap: got we=%b addr=%h data=%h want 1 00 22", oam_we, oam_addr, oam_wdata); end
      @(negedge clk);
      checks++; if (oam_we !== 1'b0) begin failures++; $display("FAIL oam_pulse: got %b want 0", oam_we); end
   endtask

   task automatic test_drop_and_reset;
      logic ok;
      cpu_wr(3'd0, 8'h00);
      cpu_rd(3'd7);
      checks++; if (cpu_rdata !== 8'h77 || v_addr !== 15'h1235) begin failures++; $display("FAIL busy_rd: got data=%h v=%h want 77 1235", cpu_rdata, v_addr); end
      cpu_rd(3'd7);
      checks++; if (cpu_rvalid !== 1'b0 || access_err !== 1'b1 || v_addr !== 15'h1235)
         begin failures++; $display("FAIL drop: got rvalid=%b err=%b v=%h want 0 1 1235", cpu_rvalid, access_err, v_addr); end
      cpu_wr(3'd1, 8'h1E);
      checks++; if (mask !== 8'h1E || vram_req !== 1'b1 || vram_addr !== 14'h1234)
         begin failures++; $display("FAIL busy_other: got mask=%h req=%b addr=%h want 1e 1 1234", mask, vram_req, vram_addr); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (vram_req !== 1'b0 || cpu_ready !== 1'b1 || access_err !== 1'b0 || v_addr !== 15'h0)
         begin failures++; $display("FAIL async_reset: got req=%b ready=%b err=%b v=%h want 0 1 0 0", vram_req, cpu_ready, access_err, v_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      vram_ack_cycle(8'hEE);
      checks++; if (vram_req !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("FAIL stale_ack: got req=%b ready=%b want 0 1", vram_req, cpu_ready); end
      cpu_rd(3'd7);
      checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL stale_rbuf: got %h want 00", cpu_rdata); end
      wait_req(ok);
      checks++; if (!ok || vram_addr !== 14'h0000) begin failures++; $display("FAIL post_reset_req: got req=%b addr=%h want 1 0000", vram_req, vram_addr); end
      vram_ack_cycle(8'h00);
   endtask

   initial begin
      rst_n = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b0; cpu_sel = 3'd0; cpu_wdata = 8'h00;
      vram_rdata = 8'h00; vram_ack = 1'b0; pal_idx = 5'h00;
      set_vblank = 1'b0; clr_vblank = 1'b0; set_sprite0 = 1'b0; set_overflow = 1'b0;
      @(negedge clk);
      test_reset;
      test_scroll;
      test_addr_write;
      test_read_buffer;
      test_palette;
      test_vblank;
      test_back_to_back;
      test_drop_and_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
